// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit
//   Iterative multiply/divide unit with HI/LO registers. It sits beside the
//   main ALU in EX and uses the same 4-bit ALU control code.
//     1010 Mult : shift-add, one multiplier bit per cycle (WIDTH cycles)
//     1111 Div  : restoring divide, one quotient bit per cycle (WIDTH cycles)
//     0101 mfhi : result = hi
//     0111 mflo : result = lo
//   Divide by zero completes at the accept edge. It sets hi=src_a,
//   lo=all-ones and raises div_by_zero.
//
//   Optional build macro SIGNED_MULDIV_EN selects two's-complement operands.
//   The unit works on magnitudes and applies the sign on the completion edge,
//   so the latency does not change.
//
// Ports
//   clk, rst_n         clock (rising edge) and async active-low reset
//   alu_ctrl, op_valid control code and its qualifier
//   src_a, src_b       rs (multiplicand/dividend), rt (multiplier/divisor)
//   result             mfhi/mflo read data, zero for other codes
//   hi, lo             architectural HI/LO registers
//   busy               iteration in flight
//   done               one-cycle pulse after HI/LO are written
//   stall              datapath must hold a muldiv-class op while busy
//   div_by_zero        last accepted Div had a zero divisor
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_ctrl,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             div_by_zero
);

    localparam logic [3:0] CTRL_MULT = 4'b1010;
    localparam logic [3:0] CTRL_DIV  = 4'b1111;
    localparam logic [3:0] CTRL_MFHI = 4'b0101;
    localparam logic [3:0] CTRL_MFLO = 4'b0111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    // The shared datapath uses these registers differently per operation.
    //   Mul: acc_hi = upper partial product, acc_lo = multiplier shifting
    //        out as the product's low half shifts in, opnd = multiplicand.
    //   Div: acc_hi = partial remainder, acc_lo = dividend shifting out as
    //        the quotient shifts in, opnd = divisor.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic is_mul_op, is_div_op, is_rd_op, accept, last;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mul_op = (alu_ctrl == CTRL_MULT);
    assign is_div_op = (alu_ctrl == CTRL_DIV);
    assign is_rd_op  = (alu_ctrl == CTRL_MFHI) || (alu_ctrl == CTRL_MFLO);
    assign accept    = (state == S_IDLE) && op_valid && (is_mul_op || is_div_op);
    assign last      = (cnt == CNT_LAST);

    assign busy  = (state != S_IDLE);
    assign stall = op_valid && busy && (is_mul_op || is_div_op || is_rd_op);

    always_comb begin
        result = '0;
        if (alu_ctrl == CTRL_MFHI)      result = hi;
        else if (alu_ctrl == CTRL_MFLO) result = lo;
    end

`ifdef SIGNED_MULDIV_EN
    logic neg_q;   // sign of product / quotient
    logic neg_r;   // sign of remainder (follows dividend)

    assign a_mag = src_a[WIDTH-1] ? (~src_a + 1'b1) : src_a;
    assign b_mag = src_b[WIDTH-1] ? (~src_b + 1'b1) : src_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            neg_r <= src_a[WIDTH-1];
        end
    end
`else
    assign a_mag = src_a;
    assign b_mag = src_b;
`endif

    // One shift-add multiply step
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // One restoring divide step. The remainder stays below the divisor, so
    // only the low WIDTH bits of the difference are ever kept.
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff, div_hi_nx, div_lo_nx;

    assign rem_sh    = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_ge    = (rem_sh >= {1'b0, opnd});
    assign rem_diff  = rem_sh[WIDTH-1:0] - opnd;
    assign div_hi_nx = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
    assign div_lo_nx = {acc_lo[WIDTH-2:0], rem_ge};

    // HI/LO values written on the completion edge
    logic [WIDTH-1:0]   fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        prod = {mul_hi_nx, mul_lo_nx};
`ifdef SIGNED_MULDIV_EN
        if (neg_q) prod = ~prod + 1'b1;
`endif
        if (state == S_MUL) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else begin
            fin_hi = div_hi_nx;
            fin_lo = div_lo_nx;
`ifdef SIGNED_MULDIV_EN
            if (neg_r) fin_hi = ~div_hi_nx + 1'b1;
            if (neg_q) fin_lo = ~div_lo_nx + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (is_div_op && (src_b == '0)) begin
                            // Completes immediately. No iterations run.
                            hi          <= src_a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                            acc_hi      <= '0;
                            if (is_mul_op) begin
                                acc_lo <= b_mag;
                                opnd   <= a_mag;
                                state  <= S_MUL;
                            end else begin
                                acc_lo <= a_mag;
                                opnd   <= b_mag;
                                state  <= S_DIV;
                            end
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (state == S_MUL) begin
                        acc_hi <= mul_hi_nx;
                        acc_lo <= mul_lo_nx;
                    end else begin
                        acc_hi <= div_hi_nx;
                        acc_lo <= div_lo_nx;
                    end
                    if (last) begin
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;

    localparam logic [3:0] MULT = 4'b1010;
    localparam logic [3:0] DIV  = 4'b1111;
    localparam logic [3:0] MFHI = 4'b0101;
    localparam logic [3:0] MFLO = 4'b0111;
    localparam logic [3:0] OTHR = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  alu_ctrl;
    logic        op_valid;
    logic [31:0] src_a, src_b;
    logic [31:0] result, hi, lo;
    logic        busy, done, stall, div_by_zero;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .alu_ctrl(alu_ctrl), .op_valid(op_valid),
        .src_a(src_a), .src_b(src_b), .result(result), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall), .div_by_zero(div_by_zero)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    task automatic ref_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] h, output logic [31:0] l);
`ifdef SIGNED_MULDIV_EN
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (c == MULT) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFFFFFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
`else
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (c == MULT) begin
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFFFFFF;
        end else begin
            h = a % b;
            l = a / b;
        end
`endif
    endtask

    // Issue one op at a negedge and follow it to completion.
    task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        logic [31:0] hi0, lo0;
        logic held, busy_ok, div0;
        int n, exp_n;
        div0 = (c == DIV) && (b == 32'd0);
        exp_n = div0 ? 1 : 33;
        hi0 = hi; lo0 = lo;
        alu_ctrl = c; op_valid = 1'b1; src_a = a; src_b = b;
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0; alu_ctrl = 4'd0;
        chk({nm, " busy_after_accept"}, 32'(busy), div0 ? 32'd0 : 32'd1);
        n = 1; held = 1'b1; busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            @(posedge clk); @(negedge clk);
            n++;
        end
        chk({nm, " edges_to_done"}, 32'(n), 32'(exp_n));
        chk({nm, " hi"}, hi, ehi);
        chk({nm, " lo"}, lo, elo);
        chk({nm, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        chk({nm, " busy_in_done"}, 32'(busy), 32'd0);
        if (!div0) begin
            chk({nm, " busy_held"}, 32'(busy_ok), 32'd1);
            chk({nm, " hilo_held"}, 32'(held), 32'd1);
        end
        @(posedge clk); @(negedge clk);
        chk({nm, " done_width"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a, b, ehi, elo;
        logic        edz;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [31:0] eh, el, hi0, lo0, ra, rb;
        logic [3:0]  rc;
        logic        stall_ok, held;
        int n;

        tbl[0] = '{MULT, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0};
`ifdef SIGNED_MULDIV_EN
        tbl[1] = '{MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0};
        tbl[4] = '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0};
        tbl[5] = '{DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
`else
        tbl[1] = '{MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0};
        tbl[4] = '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0};
        tbl[5] = '{DIV, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 1'b0};
`endif
        tbl[2] = '{DIV, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        tbl[3] = '{MULT, 32'h10000, 32'h10000, 32'h1, 32'h0, 1'b0};
        tbl[6] = '{DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};

        rst_n = 1'b0; op_valid = 1'b0; alu_ctrl = 4'd0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].a, tbl[i].b,
                   tbl[i].ehi, tbl[i].elo, tbl[i].edz);

        // Idle reads after 100/7
        alu_ctrl = MFLO; op_valid = 1'b1; #1;
        chk("mflo result", result, 32'h0E);
        chk("idle stall", 32'(stall), 32'd0);
        alu_ctrl = MFHI; #1;
        chk("mfhi result", result, 32'h02);
        alu_ctrl = OTHR; #1;
        chk("other result", result, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("other no accept", 32'(busy), 32'd0);
        op_valid = 1'b0;

        // Stall interlock, stalled Div dropped, back-to-back Mult in done cycle
        ref_calc(MULT, 32'hDEADBEEF, 32'h00012345, eh, el);
        hi0 = hi; lo0 = lo;
        alu_ctrl = MULT; op_valid = 1'b1; src_a = 32'hDEADBEEF; src_b = 32'h00012345;
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0; n = 1;
        while (n < 5) begin @(posedge clk); @(negedge clk); n++; end
        alu_ctrl = OTHR; op_valid = 1'b1; src_a = 32'd1; src_b = 32'd1; #1;
        chk("busy other no stall", 32'(stall), 32'd0);
        alu_ctrl = DIV; #1;
        chk("busy div stall", 32'(stall), 32'd1);
        @(posedge clk); @(negedge clk); n++;
        alu_ctrl = MFHI;
        stall_ok = 1'b1; held = 1'b1;
        while (!done && n < 40) begin
            #1;
            if (!stall) stall_ok = 1'b0;
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            @(posedge clk); @(negedge clk);
            n++;
        end
        chk("stall edges_to_done", 32'(n), 32'd33);
        chk("stall held high", 32'(stall_ok), 32'd1);
        chk("stall hilo_held", 32'(held), 32'd1);
        #1;
        chk("stall in done", 32'(stall), 32'd0);
        chk("stall mfhi new", result, eh);
        chk("stall lo", lo, el);
        alu_ctrl = MULT; src_a = 32'd5; src_b = 32'd9;
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0; alu_ctrl = 4'd0;
        chk("b2b accepted", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        chk("b2b edges", 32'(n), 32'd33);
        chk("b2b lo", lo, 32'd45);
        chk("b2b hi", hi, 32'd0);

        // Reset during a Div at iteration 10
        alu_ctrl = DIV; op_valid = 1'b1; src_a = 32'hFFFF0000; src_b = 32'd3;
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0; alu_ctrl = 4'd0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul3x3", MULT, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

        // Randomized ops against the arithmetic model
        for (int k = 0; k < 16; k++) begin
            rc = ($urandom_range(0, 1) == 0) ? MULT : DIV;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            ref_calc(rc, ra, rb, eh, el);
            run_op($sformatf("rnd%0d", k), rc, ra, rb, eh, el, (rc == DIV) && (rb == 32'd0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
